// File: rtl/cv32e40p_pkg.sv
// Shared types for the instruction-side OBI responder: response queue entry
// layout and the countdown helper used by the response queue.
package cv32e40p_pkg;

  // Countdown field width; bounds RESP_LATENCY to at most 256 cycles.
  localparam int unsigned CNTDN_W = 8;

  typedef logic [CNTDN_W-1:0] cntdn_t;

  // One queued fetch response: data, error flag and cycles left before it may leave.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    cntdn_t      countdown;
  } instr_resp_entry_t;

  // Countdown step that saturates at zero.
  function automatic cntdn_t cntdn_dec(input cntdn_t c);
    return (c == '0) ? c : c - cntdn_t'(1);
  endfunction

endpackage

// File: rtl/cv32e40p_instr_obi_responder_if.sv
// OBI instruction fetch bus as seen from the responder. Signal suffixes are
// relative to the responder (_i driven by the core, _o driven by the memory).
interface cv32e40p_instr_obi_responder_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  // Memory side
  modport slave (
    input  instr_req_i,
    input  instr_addr_i,
    output instr_gnt_o,
    output instr_rvalid_o,
    output instr_rdata_o,
    output instr_err_o
  );

  // Core side
  modport master (
    output instr_req_i,
    output instr_addr_i,
    input  instr_gnt_o,
    input  instr_rvalid_o,
    input  instr_rdata_o,
    input  instr_err_o
  );
endinterface

// File: rtl/cv32e40p_instr_resp_fifo.sv
// In-order response queue. Every stored countdown steps towards zero each
// cycle; the owner pops the head once its countdown has expired. A push and
// a pop may happen together, including when the queue is full.
module cv32e40p_instr_resp_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  instr_resp_entry_t i_entry,
  input  logic              i_pop,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty,
  output instr_resp_entry_t o_head
);

  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_pop;
  logic              w_do_push;
  logic [PW-1:0]     w_rd_ptr_inc;
  logic [PW-1:0]     w_wr_ptr_inc;
  instr_resp_entry_t w_slots [DEPTH];

  assign w_do_pop  = i_pop && (r_count != '0);
  // Full is fine as long as the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

  // Storage slots: load on push, otherwise run the countdown towards zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    instr_resp_entry_t r_entry;

    // Per-slot capture / countdown.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_entry <= '0;
      end else if (w_do_push && (r_wr_ptr == PW'(gi))) begin
        r_entry <= i_entry;
      end else begin
        r_entry.countdown <= cntdn_dec(r_entry.countdown);
      end
    end

    assign w_slots[gi] = r_entry;
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_do_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = w_slots[r_rd_ptr];

endmodule

// File: rtl/cv32e40p_instr_obi_responder.sv
// Instruction-side OBI memory responder with a preload port, programmable
// grant stall and fixed minimum response latency.
// Optional feature macro: CV32E40P_INSTR_RESP_ERR_EN -- when defined, fetches
// beyond MEM_WORDS return an error with zero data; otherwise the address wraps.
module cv32e40p_instr_obi_responder
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1,
  localparam int unsigned AW = $clog2(MEM_WORDS),
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  cv32e40p_instr_obi_responder_if.slave bus,
  input  logic [3:0]                   gnt_stall_i,
  input  logic                         load_we_i,
  input  logic [AW-1:0]                load_addr_i,
  input  logic [31:0]                  load_wdata_i,
  output logic                         busy_o
);

  logic [31:0]       r_mem [MEM_WORDS];
  logic [3:0]        r_wait_cnt;
  logic [AW-1:0]     w_idx;
  logic [31:0]       w_mem_rdata;
  logic [31:0]       w_rdata;
  logic              w_err;
  logic              w_gnt;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  instr_resp_entry_t w_head;
  instr_resp_entry_t w_push_entry;

  // Preload port; memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (load_we_i) begin
      r_mem[load_addr_i] <= load_wdata_i;
    end
  end

  assign w_idx = bus.instr_addr_i[AW+1:2];

  // A preload hitting the granted word wins, so the fetch sees the new data.
  assign w_mem_rdata = (load_we_i && (load_addr_i == w_idx)) ? load_wdata_i : r_mem[w_idx];

`ifdef CV32E40P_INSTR_RESP_ERR_EN
  logic w_oor;
  logic w_unused_addr;
  assign w_oor         = (bus.instr_addr_i[31:2] >= 30'(MEM_WORDS));
  assign w_rdata       = w_oor ? 32'h0 : w_mem_rdata;
  assign w_err         = w_oor;
  assign w_unused_addr = ^bus.instr_addr_i[1:0];
`else
  logic w_unused_addr;
  assign w_rdata       = w_mem_rdata;
  assign w_err         = 1'b0;
  assign w_unused_addr = ^{bus.instr_addr_i[31:AW+2], bus.instr_addr_i[1:0]};
`endif

  // Head leaves once its countdown expires; slots only hold earlier pushes.
  assign w_pop = !w_empty && (w_head.countdown == '0);

  // Grant after the stall has elapsed and while a queue slot is (or becomes) free.
  assign w_gnt = !rst && bus.instr_req_i && (r_wait_cnt >= gnt_stall_i) && (!w_full || w_pop);

  // Count cycles a request has waited without grant, saturating at 15.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'h0;
    end else if (!bus.instr_req_i || w_gnt) begin
      r_wait_cnt <= 4'h0;
    end else if (r_wait_cnt != 4'hF) begin
      r_wait_cnt <= r_wait_cnt + 4'h1;
    end
  end

  // Assemble the response captured in the grant cycle.
  always_comb begin
    w_push_entry           = '0;
    w_push_entry.rdata     = w_rdata;
    w_push_entry.err       = w_err;
    w_push_entry.countdown = CNTDN_W'(RESP_LATENCY - 1);
  end

  cv32e40p_instr_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_gnt),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.instr_gnt_o    = w_gnt;
  assign bus.instr_rvalid_o = w_pop;
  assign bus.instr_rdata_o  = w_pop ? w_head.rdata : 32'h0;
  assign bus.instr_err_o    = w_pop ? w_head.err : 1'b0;
  assign busy_o             = (w_count != '0);

endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
// Bench for cv32e40p_instr_obi_responder: two instances (latency 1 and 3)
// share one stimulus stream; a transaction-level model predicts each.
module tb_cv32e40p_instr_obi_responder;

  localparam int MW = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } mresp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  stall;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;
  logic        busy1, busy3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] mem_m [MW];
  mresp_t      mq [2][$];
  int          wcnt [2];

  // Last observed outputs per instance (0: latency 1, 1: latency 3)
  logic        obs_g [2];
  logic        obs_v [2];
  logic [31:0] obs_d [2];
  logic        obs_e [2];
  logic        obs_b [2];

  cv32e40p_instr_obi_responder_if bus1();
  cv32e40p_instr_obi_responder_if bus3();

  assign bus1.instr_req_i  = req;
  assign bus1.instr_addr_i = addr;
  assign bus3.instr_req_i  = req;
  assign bus3.instr_addr_i = addr;

  cv32e40p_instr_obi_responder #(
    .MEM_WORDS(MW), .MAX_OUTSTANDING(2), .RESP_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .gnt_stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .busy_o(busy1)
  );

  cv32e40p_instr_obi_responder #(
    .MEM_WORDS(MW), .MAX_OUTSTANDING(2), .RESP_LATENCY(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .gnt_stall_i(stall),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .busy_o(busy3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What a fetch of address a returns this cycle (write-first on preload hit).
  task automatic model_read(input logic [31:0] a, output logic [31:0] dt, output logic er);
    logic [9:0] idx;
    idx = a[11:2];
`ifdef CV32E40P_INSTR_RESP_ERR_EN
    if (a[31:2] >= 30'(MW)) begin
      dt = 32'h0;
      er = 1'b1;
      return;
    end
`endif
    dt = (load_we && load_addr == idx) ? load_wdata : mem_m[idx];
    er = 1'b0;
  endtask

  // One clock cycle: compare both instances with the model, then advance.
  task automatic step();
    logic [31:0] md, o_d, ed;
    logic        me, pop_m, gnt_m, o_g, o_v, o_e, o_b;
    int          lat;
    @(negedge clk);
    model_read(addr, md, me);
    for (int d = 0; d < 2; d++) begin
      lat   = (d == 0) ? 1 : 3;
      pop_m = (mq[d].size() > 0) && (mq[d][0].due <= cyc);
      gnt_m = req && (wcnt[d] >= int'(stall)) && ((mq[d].size() < 2) || pop_m);
      if (d == 0) begin
        o_g = bus1.instr_gnt_o; o_v = bus1.instr_rvalid_o; o_d = bus1.instr_rdata_o;
        o_e = bus1.instr_err_o; o_b = busy1;
      end else begin
        o_g = bus3.instr_gnt_o; o_v = bus3.instr_rvalid_o; o_d = bus3.instr_rdata_o;
        o_e = bus3.instr_err_o; o_b = busy3;
      end
      obs_g[d] = o_g; obs_v[d] = o_v; obs_d[d] = o_d; obs_e[d] = o_e; obs_b[d] = o_b;
      ed = pop_m ? mq[d][0].data : 32'h0;
      chk($sformatf("d%0d_gnt c%0d", d, cyc), {31'b0, o_g}, {31'b0, gnt_m});
      chk($sformatf("d%0d_rvalid c%0d", d, cyc), {31'b0, o_v}, {31'b0, pop_m});
      chk($sformatf("d%0d_rdata c%0d", d, cyc), o_d, ed);
      chk($sformatf("d%0d_err c%0d", d, cyc), {31'b0, o_e}, {31'b0, pop_m ? mq[d][0].err : 1'b0});
      chk($sformatf("d%0d_busy c%0d", d, cyc), {31'b0, o_b}, {31'b0, mq[d].size() != 0});
      if (pop_m) begin
        $display("c%0d dut_lat%0d resp rdata=%h err=%0b", cyc, lat, o_d, o_e);
        void'(mq[d].pop_front());
      end
      if (gnt_m) begin
        mq[d].push_back('{data: md, err: me, due: cyc + lat});
      end
      if (!req || gnt_m) wcnt[d] = 0;
      else if (wcnt[d] < 15) wcnt[d]++;
    end
    if (load_we) mem_m[load_addr] = load_wdata;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; load_we = 1'b0; stall = 4'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int   n;
    logic [3:0] pat;

    rst = 1'b1; req = 1'b1; addr = 32'h0; stall = 4'd0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
    wcnt[0] = 0; wcnt[1] = 0;

    // Reset state: everything low, even with a request pending.
    #1;
    chk("rst_gnt1", {31'b0, bus1.instr_gnt_o}, 32'h0);
    chk("rst_gnt3", {31'b0, bus3.instr_gnt_o}, 32'h0);
    chk("rst_rvalid1", {31'b0, bus1.instr_rvalid_o}, 32'h0);
    chk("rst_rdata1", bus1.instr_rdata_o, 32'h0);
    chk("rst_err1", {31'b0, bus1.instr_err_o}, 32'h0);
    chk("rst_busy3", {31'b0, busy3}, 32'h0);
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Preload words 0..63.
    for (int i = 0; i < 64; i++) begin
      load_we = 1'b1;
      load_addr = 10'(i);
      load_wdata = (i == 16) ? 32'hDEADBEEF : $urandom;
      step();
    end
    load_we = 1'b0;
    step();

    // Zero-stall fetch of word 0x10.
    req = 1'b1; addr = 32'h0000_0040;
    step();
    chk("r027_gnt_same_cycle", {31'b0, obs_g[0]}, 32'h1);
    req = 1'b0;
    step();
    chk("r027_rvalid_next", {31'b0, obs_v[0]}, 32'h1);
    chk("r027_rdata", obs_d[0], 32'hDEADBEEF);
    idle(4);

    // Stall of 3: grant in the 4th request cycle, twice back to back.
    stall = 4'd3; req = 1'b1; addr = 32'h0000_0044;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!obs_g[0] && n < 10);
      chk($sformatf("r028_gnt_cycle_%0d", k), 32'(n), 32'd4);
    end
    idle(5);

    // Latency 3, depth 2, request held: grant pattern 1,1,0,1.
    req = 1'b1; pat = '0;
    for (int i = 0; i < 4; i++) begin
      addr = {20'h0, 4'h0, 6'($urandom_range(63)), 2'b00};
      step();
      pat[i] = obs_g[1];
      if (i == 3) chk("r029_rvalid_at_3rd_gnt", {31'b0, obs_v[1]}, 32'h1);
    end
    chk("r029_gnt_pattern", {28'b0, pat}, 32'hB);
    idle(6);

    // Address beyond the memory.
    req = 1'b1; addr = 32'h0000_1000;
    step();
    req = 1'b0;
    step();
    chk("r030_rvalid", {31'b0, obs_v[0]}, 32'h1);
`ifdef CV32E40P_INSTR_RESP_ERR_EN
    chk("r030_err", {31'b0, obs_e[0]}, 32'h1);
    chk("r030_rdata", obs_d[0], 32'h0);
`else
    chk("r030_err", {31'b0, obs_e[0]}, 32'h0);
    chk("r030_rdata", obs_d[0], mem_m[0]);
`endif
    idle(4);

    // Preload colliding with the granted word.
    req = 1'b1; addr = 32'h0000_0014;
    load_we = 1'b1; load_addr = 10'd5; load_wdata = 32'h12345678;
    step();
    req = 1'b0; load_we = 1'b0;
    step();
    chk("r031_rvalid", {31'b0, obs_v[0]}, 32'h1);
    chk("r031_rdata", obs_d[0], 32'h12345678);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      req = ($urandom_range(9) < 7);
      addr = $urandom & 32'hFFFF_F0FF;
      if ($urandom_range(1) == 1) addr[31:12] = '0;
      stall = ($urandom_range(3) == 0) ? 4'($urandom_range(5)) : 4'd0;
      load_we = ($urandom_range(7) == 0);
      load_addr = 10'($urandom_range(63));
      load_wdata = $urandom;
      step();
    end
    idle(6);

    // Reset with two responses outstanding.
    req = 1'b1; addr = 32'h0000_0008;
    step();
    addr = 32'h0000_000C;
    step();
    req = 1'b0;
    chk("r032_busy3_before", {31'b0, busy3}, 32'h1);
    rst = 1'b1;
    #1;
    chk("r032_busy3_now", {31'b0, busy3}, 32'h0);
    chk("r032_rvalid3_now", {31'b0, bus3.instr_rvalid_o}, 32'h0);
    chk("r032_busy1_now", {31'b0, busy1}, 32'h0);
    chk("r032_rvalid1_now", {31'b0, bus1.instr_rvalid_o}, 32'h0);
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      wcnt[d] = 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);

    // Memory survives reset; a new fetch still answers.
    req = 1'b1; addr = 32'h0000_0040;
    step();
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_instr_obi_responder.md
CV32E40P_INSTR_OBI_RESPONDER -- requirements
Module: cv32e40p_instr_obi_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, instruction memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, response queue depth (>=1).
REQ-003 SHALL have parameter RESP_LATENCY, default 1, cycles from grant to earliest rvalid (>=1).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: instr_req_i in 1 fetch request; instr_addr_i in 32 byte address; instr_gnt_o out 1 grant.
REQ-006 SHALL have ports: instr_rvalid_o out 1 response valid; instr_rdata_o out 32 read data; instr_err_o out 1 bus error (qualified by rvalid).
REQ-007 SHALL have ports: gnt_stall_i in 4 cycles a pending request waits before grant.
REQ-008 SHALL have ports: load_we_i in 1 preload write; load_addr_i in $clog2(MEM_WORDS) word index; load_wdata_i in 32 preload data.
REQ-009 SHALL have port busy_o out 1 high when any response is outstanding.

Function
REQ-010 SHALL implement the OBI instruction-side responder: instr_addr_i sampled only in the grant cycle (instr_req_i && instr_gnt_o); addr[1:0] ignored.
REQ-011 SHALL drive instr_gnt_o combinationally = instr_req_i && (wait_cnt >= gnt_stall_i) && (queue_count < MAX_OUTSTANDING || pop_this_cycle).
REQ-012 SHALL increment 4-bit wait_cnt (saturating at 15) each cycle instr_req_i is high without grant; clear it on grant or when instr_req_i is low.
REQ-013 SHALL read the memory word in the grant cycle and push {rdata, err, countdown=RESP_LATENCY-1} into an in-order queue.
REQ-014 SHALL decrement every non-zero queue countdown each cycle; head is poppable when its countdown is 0 and it was pushed in an earlier cycle.
REQ-015 SHALL assert instr_rvalid_o for exactly one cycle per popped entry, in grant order, at most one per cycle; no back-pressure exists.
REQ-016 SHALL hold instr_rdata_o and instr_err_o at 0 when instr_rvalid_o is low.
REQ-017 SHALL give write-first semantics when load_we_i targets the word being granted in the same cycle (granted data = load_wdata_i).
REQ-018 SHALL allow push and pop in the same cycle at full; queue count unchanged.
REQ-019 SHALL set busy_o = (queue_count != 0).
REQ-020 SHALL guarantee zero-cycle grant (gnt same cycle as req) when gnt_stall_i==0 and queue not full.

Reset
REQ-021 SHALL, on rst high, clear queue, wait_cnt and all outputs to 0 asynchronously; memory contents are not reset.
REQ-022 SHALL discard outstanding responses on reset mid-operation; first rvalid after reset only follows a new grant.

Configuration
REQ-023 SHALL, with CV32E40P_INSTR_RESP_ERR_EN defined, return instr_err_o=1 and rdata 0 for word index >= MEM_WORDS (addr[31:2]).
REQ-024 SHALL, without CV32E40P_INSTR_RESP_ERR_EN, index memory with addr modulo MEM_WORDS and tie instr_err_o to 0.

Structure
REQ-025 SHALL place typedef instr_resp_entry_t (rdata, err, countdown) in cv32e40p_pkg.
REQ-026 SHALL implement the queue as sub-module cv32e40p_instr_resp_fifo (push, pop, count, full, empty, head).

Verification
REQ-027 Preload word 0x10=0xDEADBEEF, req addr 0x40, stall 0, latency 1 -> gnt same cycle, rvalid next cycle with 0xDEADBEEF.
REQ-028 gnt_stall_i=3, req held -> gnt in 4th cycle of req, wait_cnt cleared afterwards.
REQ-029 MAX_OUTSTANDING=2, RESP_LATENCY=3, req held continuously -> 2 grants, third grant only in cycle of first rvalid; responses in order.
REQ-030 With CV32E40P_INSTR_RESP_ERR_EN, MEM_WORDS=1024, addr 0x0000_1000 -> rvalid with err=1, rdata=0; without macro -> data of word 0, err=0.
REQ-031 load_we_i to word 5 with 0x12345678 in same cycle as grant of addr 0x14 -> response rdata 0x12345678.
REQ-032 Assert rst with 2 responses outstanding -> rvalid/busy_o immediately 0, no stale rvalid after release.
